// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the four-master bus arbiter.
package bus_arbiter_pkg;

  localparam int unsigned MAX_HOLD_DEF = 16;
  localparam int unsigned NUM_MASTERS  = 4;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam logic [1:0] BUS_OWNER_MASTER_0 = 2'd0;
  localparam logic [1:0] BUS_OWNER_MASTER_1 = 2'd1;
  localparam logic [1:0] BUS_OWNER_MASTER_2 = 2'd2;
  localparam logic [1:0] BUS_OWNER_MASTER_3 = 2'd3;

  typedef logic [1:0] bus_owner_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } bus_state_e;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Rotating-priority search: first set bit of req starting at start, wrapping
// modulo 4. With excl_own set, the slot just before start (the current owner)
// is skipped so a busy owner never re-picks itself.
module bus_rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] start,
  input  logic       excl_own,
  output logic [1:0] idx,
  output logic       vld
);

  logic [1:0] cand;

  // Scan from the farthest slot back to start so the nearest requester wins.
  always_comb begin
    idx  = start;
    vld  = 1'b0;
    cand = '0;
    for (int k = 3; k >= 0; k--) begin
      cand = start + 2'(k);
      if (req[cand] && !(excl_own && k == 3)) begin
        idx = cand;
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Four-master bus arbiter: rotating priority, registered active-low grants,
// forced re-arbitration after MAX_HOLD cycles when someone else is waiting.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output logic [1:0] bus_owner,
  output logic       bus_busy
);

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD - 1);

  bus_state_e state_q, state_d;
  bus_owner_t owner_q, owner_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] grnt_q;
  logic [3:0] req_act;
  logic [1:0] nxt_ptr;
  logic [1:0] pick_idx;
  logic       pick_vld;
  logic       own_req;

  assign req_act = ~{m3_req_, m2_req_, m1_req_, m0_req_};
  assign nxt_ptr = owner_q + 2'd1;
  assign own_req = req_act[owner_q];

  // In IDLE the old owner is still eligible (searched last); in BUSY it is excluded.
  bus_rr_pick u_pick (
    .req      (req_act),
    .start    (nxt_ptr),
    .excl_own (state_q == ST_BUSY),
    .idx      (pick_idx),
    .vld      (pick_vld)
  );

  // Next-state: grant, hand over on release, preempt at hold limit, or idle.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        hold_d = '0;
        if (pick_vld) begin
          state_d = ST_BUSY;
          owner_d = pick_idx;
        end
      end
      ST_BUSY: begin
        if (!own_req || (hold_q == HOLD_MAX && pick_vld)) begin
          hold_d = '0;
          if (pick_vld) owner_d = pick_idx;
          else          state_d = ST_IDLE;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = '0;
      end
    endcase
  end

  // State, owner pointer, hold counter and grant lines, all registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= BUS_OWNER_MASTER_3;
      hold_q  <= '0;
      grnt_q  <= {4{DISABLE_}};
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      grnt_q  <= (state_d == ST_BUSY) ? ~(4'b0001 << owner_d) : {4{DISABLE_}};
    end
  end

  assign m0_grnt_  = grnt_q[0];
  assign m1_grnt_  = grnt_q[1];
  assign m2_grnt_  = grnt_q[2];
  assign m3_grnt_  = grnt_q[3];
  assign bus_owner = owner_q;
  assign bus_busy  = (state_q == ST_BUSY);

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a behavioural model predicts each cycle's
// outputs, predictions are queued at drive time and compared after the edge.
module tb_bus_arbiter;

  localparam int MH    = 4;
  localparam int BOUND = 3 * MH + 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_n;
  logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
  logic [1:0] bus_owner;
  logic       bus_busy;
  logic [3:0] grnt_n;

  always #5 clk = ~clk;

  bus_arbiter #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req_   (req_n[0]),
    .m1_req_   (req_n[1]),
    .m2_req_   (req_n[2]),
    .m3_req_   (req_n[3]),
    .m0_grnt_  (m0_grnt_),
    .m1_grnt_  (m1_grnt_),
    .m2_grnt_  (m2_grnt_),
    .m3_grnt_  (m3_grnt_),
    .bus_owner (bus_owner),
    .bus_busy  (bus_busy)
  );

  assign grnt_n = {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};

  typedef struct packed {
    logic       busy;
    logic [1:0] owner;
    logic [3:0] grnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state.
  bit       m_busy = 1'b0;
  bit [1:0] m_own  = 2'd3;
  int       m_hold = 0;

  int wait_cnt [4];
  int max_wait = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Advance the model one edge using the current inputs.
  task automatic model_edge();
    bit [3:0] rq;
    bit       found;
    bit [1:0] c;
    rq = ~req_n;
    if (reset) begin
      m_busy = 1'b0; m_own = 2'd3; m_hold = 0;
    end else if (!m_busy) begin
      m_hold = 0;
      found  = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        c = m_own + 2'(k);
        if (!found && rq[c]) begin found = 1'b1; m_busy = 1'b1; m_own = c; end
      end
    end else begin
      bit others;
      others = 1'b0;
      for (int i = 0; i < 4; i++) if (rq[i] && 2'(i) != m_own) others = 1'b1;
      if (!rq[m_own] || (m_hold == MH - 1 && others)) begin
        found = 1'b0;
        for (int k = 1; k <= 3; k++) begin
          c = m_own + 2'(k);
          if (!found && rq[c]) begin found = 1'b1; m_own = c; end
        end
        if (!found) m_busy = 1'b0;
        m_hold = 0;
      end else if (m_hold < MH - 1) begin
        m_hold++;
      end
    end
  endtask

  // One clock: track waits, predict, clock, compare.
  task automatic step();
    exp_t e, got;
    logic [3:0] gi;
    for (int i = 0; i < 4; i++) begin
      if (reset) wait_cnt[i] = 0;
      else if (!req_n[i] && grnt_n[i]) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
    end
    model_edge();
    e.busy  = m_busy;
    e.owner = m_own;
    e.grnt  = m_busy ? ~(4'b0001 << m_own) : 4'hF;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      got = '{busy: bus_busy, owner: bus_owner, grnt: grnt_n};
      e = sb.pop_front();
      chk("sb_out", 32'(got), 32'(e));
    end
    chk("onehot", 32'($countones(~grnt_n) <= 1), 32'd1);
    gi = bus_busy ? ~(4'b0001 << bus_owner) : 4'hF;
    chk("gidx", 32'(grnt_n), 32'(gi));
  endtask

  initial begin
    reset = 1'b1;
    req_n = 4'hF;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    step(); step();
    chk("rst_grnt",  32'(grnt_n),    32'hF);
    chk("rst_busy",  32'(bus_busy),  32'd0);
    chk("rst_owner", 32'(bus_owner), 32'd3);

    // m0 alone: granted one cycle later
    reset = 1'b0;
    req_n = 4'b1110;
    step();
    chk("r024_g0",   32'(m0_grnt_),  32'd0);
    chk("r024_own",  32'(bus_owner), 32'd0);
    chk("r024_busy", 32'(bus_busy),  32'd1);

    // m0 releases, m1..m3 request: 1,2,3 with no idle gaps
    req_n = 4'b0001; step();
    chk("r025_o1", 32'(bus_owner), 32'd1);
    req_n = 4'b0011; step();
    chk("r025_o2", 32'(bus_owner), 32'd2);
    chk("r025_b2", 32'(bus_busy),  32'd1);
    req_n = 4'b0111; step();
    chk("r025_o3", 32'(bus_owner), 32'd3);

    // owner 3 releases with m0 and m2 waiting: wrap to 0
    req_n = 4'b1010; step();
    chk("r026_g0", 32'(m0_grnt_), 32'd0);

    // preemption at MAX_HOLD
    reset = 1'b1; req_n = 4'hF; step();
    reset = 1'b0; req_n = 4'b1101; step();
    chk("r027_g1", 32'(bus_owner), 32'd1);
    req_n = 4'b1001;
    step(); step(); step();
    chk("r027_hold", 32'(m1_grnt_), 32'd0);
    step();
    chk("r027_pre", 32'(m2_grnt_), 32'd0);
    req_n = 4'b1101; step();
    chk("r027_back", 32'(m1_grnt_), 32'd0);
    for (int i = 0; i < 3 * MH; i++) step();
    chk("r027_alone", 32'(m1_grnt_), 32'd0);

    // reset while m2 owns the bus
    req_n = 4'b1011; step();
    chk("r028_own2", 32'(bus_owner), 32'd2);
    reset = 1'b1; step();
    chk("r028_grnt",  32'(grnt_n),    32'hF);
    chk("r028_owner", 32'(bus_owner), 32'd3);
    reset = 1'b0; step();
    chk("r028_regr", 32'(m2_grnt_), 32'd0);

    // random traffic with occasional reset
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    max_wait = 0;
    for (int n = 0; n < 10000; n++) begin
      reset = ($urandom_range(0, 999) == 0);
      req_n = 4'($urandom);
      step();
    end
    reset = 1'b0;
    chk("starve", 32'(max_wait <= BOUND), 32'd1);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
